// File: rtl/pipo_frame_rx.sv
// Multi-lane frame-synchronised serial-to-parallel receiver with valid/ack output hold.
// Optional overrun detection is built only when PIPO_OVERRUN_EN is defined.
module pipo_frame_rx #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2
) (
    input  logic                      Dclk,
    input  logic                      Clear_n,
    input  logic                      Frame,
    input  logic [CHANNELS-1:0]       InputS,
    output logic [CHANNELS*WIDTH-1:0] data_out,
    output logic                      data_valid,
    input  logic                      data_ack,
    output logic                      busy,
    output logic                      frame_err,
    output logic                      overrun
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [CHANNELS*(WIDTH-1)-1:0] sh_q, sh_d;
    logic [CHANNELS*WIDTH-1:0]     dout_q, dout_d;
    logic                          vld_q, vld_d;
    logic                          ferr_q, ferr_d;
    logic [CHANNELS*WIDTH-1:0]     asm_w;
    logic [CHANNELS*(WIDTH-1)-1:0] cap_w;
    logic                          done;

    // Full word as it would look with this edge's bit appended as LSB.
    always_comb begin
        asm_w = '0;
        cap_w = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            asm_w[c*WIDTH +: WIDTH]         = {sh_q[c*(WIDTH-1) +: WIDTH-1], InputS[c]};
            cap_w[c*(WIDTH-1) +: WIDTH-1]   = (WIDTH-1)'(InputS[c]);
        end
    end

`ifdef PIPO_OVERRUN_EN
    logic ovr_q, ovr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        vld_d   = vld_q;
        ferr_d  = 1'b0;
        done    = 1'b0;
`ifdef PIPO_OVERRUN_EN
        ovr_d   = ovr_q;
        if (data_ack)
            ovr_d = 1'b0;
`endif
        if (data_ack)
            vld_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (Frame) begin
                    sh_d    = cap_w;
                    cnt_d   = CW'(WIDTH-2);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (Frame) begin
                    sh_d   = cap_w;
                    cnt_d  = CW'(WIDTH-2);
                    ferr_d = 1'b1;
                end else if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    for (int c = 0; c < CHANNELS; c++)
                        sh_d[c*(WIDTH-1) +: WIDTH-1] = asm_w[c*WIDTH +: WIDTH-1];
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A held, unacknowledged word is either protected or overwritten.
        if (done) begin
`ifdef PIPO_OVERRUN_EN
            if (!vld_q || data_ack) begin
                dout_d = asm_w;
                vld_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
`else
            dout_d = asm_w;
            vld_d  = 1'b1;
`endif
        end
    end

    always_ff @(negedge Dclk or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    // Partial-word storage needs no reset: it is always reloaded by a Frame edge.
    always_ff @(negedge Dclk) begin
        sh_q <= sh_d;
    end

`ifdef PIPO_OVERRUN_EN
    always_ff @(negedge Dclk or negedge Clear_n) begin
        if (!Clear_n)
            ovr_q <= 1'b0;
        else
            ovr_q <= ovr_d;
    end
    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

    assign data_out   = dout_q;
    assign data_valid = vld_q;
    assign busy       = (state_q == SHIFT);
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_pipo_frame_rx.sv
// Directed bench for pipo_frame_rx (WIDTH=16, CHANNELS=2); inputs driven 1 unit after each falling edge.
module tb_pipo_frame_rx;
    localparam int W  = 16;
    localparam int CH = 2;

    logic              Dclk;
    logic              Clear_n;
    logic              Frame;
    logic [CH-1:0]     InputS;
    logic [CH*W-1:0]   data_out;
    logic              data_valid;
    logic              data_ack;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    int n_checks;
    int n_fail;

    pipo_frame_rx #(.WIDTH(W), .CHANNELS(CH)) dut (
        .Dclk       (Dclk),
        .Clear_n    (Clear_n),
        .Frame      (Frame),
        .InputS     (InputS),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial begin
        Dclk = 1'b1;
        forever #5 Dclk = ~Dclk;
    end

    task automatic step(input logic f, input logic b0, input logic b1, input logic a);
        Frame    = f;
        InputS   = {b1, b0};
        data_ack = a;
        @(negedge Dclk);
        #1;
    endtask

    task automatic test_reset;
        Clear_n = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        n_checks++;
        if ({data_out, data_valid, busy, frame_err, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dout=%h v=%b b=%b fe=%b ov=%b want all 0",
                     data_out, data_valid, busy, frame_err, overrun);
        end
        Clear_n = 1'b1;
        step(0, 0, 0, 0);
    endtask

    task automatic test_single;
        logic [15:0] a, b;
        a = 16'hA5C3;
        b = 16'h1234;
        for (int i = 0; i < W; i++) begin
            step(i == 0, a[15-i], b[15-i], 0);
            if (i == 0) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_busy_start: got %b want 1", busy);
                end
            end
            if (i == 14) begin
                n_checks++;
                if (busy !== 1'b1 || data_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_edge14: got busy=%b valid=%b want 1/0", busy, data_valid);
                end
            end
        end
        n_checks++;
        if (data_out !== 32'h1234_A5C3 || data_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got dout=%h v=%b busy=%b want 1234a5c3/1/0",
                     data_out, data_valid, busy);
        end
    endtask

    task automatic test_hold_ack;
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0);
            n_checks++;
            if (data_valid !== 1'b1 || data_out !== 32'h1234_A5C3) begin
                n_fail++;
                $display("FAIL hold_stable: edge %0d got dout=%h v=%b want 1234a5c3/1",
                         i, data_out, data_valid);
            end
        end
        step(0, 0, 0, 1);
        n_checks++;
        if (data_valid !== 1'b0 || data_out !== 32'h1234_A5C3) begin
            n_fail++;
            $display("FAIL ack_clears: got dout=%h v=%b want 1234a5c3/0", data_out, data_valid);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] a, b;
        a = 16'h0001;
        b = 16'hFFFF;
        for (int i = 0; i < W; i++)
            step(i == 0, a[15-i], b[15-i], i == W-1);
        n_checks++;
        if (data_out !== 32'hFFFF_0001 || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: got dout=%h v=%b want ffff0001/1", data_out, data_valid);
        end
        for (int i = 0; i < W; i++) begin
            step(i == 0, b[15-i], a[15-i], i == W-1);
            n_checks++;
            if (data_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_valid_cont: edge %0d got v=%b want 1", i, data_valid);
            end
        end
        n_checks++;
        if (data_out !== 32'h0001_FFFF || overrun !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got dout=%h ov=%b busy=%b want 0001ffff/0/0",
                     data_out, overrun, busy);
        end
    endtask

    task automatic test_overrun;
        logic [15:0] a, b;
        a = 16'h1111;
        b = 16'h2222;
        for (int i = 0; i < W; i++)
            step(i == 0, a[15-i], b[15-i], 0);
`ifdef PIPO_OVERRUN_EN
        n_checks++;
        if (data_out !== 32'h0001_FFFF || overrun !== 1'b1 || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_drop: got dout=%h ov=%b v=%b want 0001ffff/1/1",
                     data_out, overrun, data_valid);
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b want 1", overrun);
        end
`else
        n_checks++;
        if (data_out !== 32'h2222_1111 || overrun !== 1'b0 || data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overwrite: got dout=%h ov=%b v=%b want 22221111/0/1",
                     data_out, overrun, data_valid);
        end
`endif
        step(0, 0, 0, 1);
        n_checks++;
        if (overrun !== 1'b0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_ack_clear: got ov=%b v=%b want 0/0", overrun, data_valid);
        end
    endtask

    task automatic test_frame_err;
        logic [15:0] j0, j1, a, b;
        j0 = 16'h0F0F;
        j1 = 16'h7777;
        a  = 16'hBEEF;
        b  = 16'hCAFE;
        for (int i = 0; i < 8; i++)
            step(i == 0, j0[15-i], j1[15-i], 0);
        n_checks++;
        if (frame_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_before: got fe=%b busy=%b want 0/1", frame_err, busy);
        end
        for (int i = 0; i < W; i++) begin
            step(i == 0, a[15-i], b[15-i], 0);
            if (i == 0) begin
                n_checks++;
                if (frame_err !== 1'b1 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ferr_pulse: got fe=%b busy=%b want 1/1", frame_err, busy);
                end
            end
            if (i == 1) begin
                n_checks++;
                if (frame_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ferr_one_cycle: got %b want 0", frame_err);
                end
            end
            if (i == 14) begin
                n_checks++;
                if (data_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ferr_discard: got v=%b want 0", data_valid);
                end
            end
        end
        n_checks++;
        if (data_out !== 32'hCAFE_BEEF || data_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_restart_word: got dout=%h v=%b busy=%b want cafebeef/1/0",
                     data_out, data_valid, busy);
        end
    endtask

    task automatic test_clear;
        logic [15:0] a, b;
        a = 16'h1357;
        b = 16'h2468;
        for (int i = 0; i < 5; i++)
            step(i == 0, a[15-i], b[15-i], 0);
        Clear_n = 1'b0;
        #2;
        n_checks++;
        if ({data_out, data_valid, busy, frame_err, overrun} !== '0) begin
            n_fail++;
            $display("FAIL clear_async: got dout=%h v=%b b=%b fe=%b ov=%b want all 0",
                     data_out, data_valid, busy, frame_err, overrun);
        end
        Clear_n = 1'b1;
        step(0, 1, 1, 0);
        n_checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_idle: got busy=%b v=%b want 0/0", busy, data_valid);
        end
        a = 16'h0F0F;
        b = 16'hF0F0;
        for (int i = 0; i < W; i++)
            step(i == 0, a[15-i], b[15-i], 0);
        n_checks++;
        if (data_out !== 32'hF0F0_0F0F || data_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_next_word: got dout=%h v=%b ov=%b want f0f00f0f/1/0",
                     data_out, data_valid, overrun);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        Clear_n  = 1'b0;
        Frame    = 1'b0;
        InputS   = '0;
        data_ack = 1'b0;
        test_reset();
        test_single();
        test_hold_ack();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
